// File: rtl/adbg_or1k_stall_sequencer.sv
// Debug stall/reset sequencer for NB_CORES OR1K cores. Host commands become per-core
// stall and reset masks, and per-core breakpoints are merged into sticky stall state.
module adbg_or1k_stall_sequencer #(
   parameter int unsigned NB_CORES     = 4,
   parameter int unsigned SETTLE_CYC   = 2,
   parameter int unsigned RST_LEN      = 8,
   parameter bit          BP_STALL_ALL = 1'b1
) (
   input  logic                tck_i,
   input  logic                rst_i,
   input  logic                cmd_valid_i,
   output logic                cmd_ready_o,
   input  logic [1:0]          cmd_op_i,
   input  logic [NB_CORES-1:0] cmd_mask_i,
   input  logic [NB_CORES-1:0] bp_i,
   output logic [NB_CORES-1:0] stall_o,
   output logic [NB_CORES-1:0] cpu_rst_o,
   output logic [NB_CORES-1:0] bp_hit_o,
   output logic                busy_o,
   output logic                cmd_done_o
);

   localparam int unsigned MaxCyc = (SETTLE_CYC > RST_LEN) ? SETTLE_CYC : RST_LEN;
   localparam int unsigned CntW   = $clog2(MaxCyc + 1);

   localparam logic [1:0] OpStall   = 2'b01;
   localparam logic [1:0] OpUnstall = 2'b10;
   localparam logic [1:0] OpReset   = 2'b11;

   typedef enum logic [2:0] {
      StIdle,
      StStallWait,
      StRstAssert,
      StRstRelease,
      StDone
   } state_e;

   state_e              state_q, state_d;
   logic [CntW-1:0]     cnt_q, cnt_d;
   logic [NB_CORES-1:0] mask_q, mask_d;
   logic [NB_CORES-1:0] stall_q, stall_d;
   logic [NB_CORES-1:0] hit_q, hit_d;
   logic [NB_CORES-1:0] crst_q, crst_d;

   always_ff @(posedge tck_i) begin
      if (rst_i) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         mask_q  <= '0;
         stall_q <= '0;
         hit_q   <= '0;
         crst_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mask_q  <= mask_d;
         stall_q <= stall_d;
         hit_q   <= hit_d;
         crst_q  <= crst_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = (cnt_q != '0) ? cnt_q - 1'b1 : '0;
      mask_d  = mask_q;
      stall_d = stall_q;
      hit_d   = hit_q;
      crst_d  = '0;

      case (state_q)
         StIdle: begin
            if (cmd_valid_i) begin
               mask_d  = cmd_mask_i;
               state_d = StDone;
               cnt_d   = '0;
               // A zero mask turns any op into a plain acknowledge.
               if (cmd_mask_i != '0) begin
                  case (cmd_op_i)
                     OpStall: stall_d = stall_q | cmd_mask_i;
                     OpUnstall: begin
                        stall_d = stall_q & ~cmd_mask_i;
                        hit_d   = hit_q & ~cmd_mask_i;
                     end
                     OpReset: begin
                        stall_d = stall_q | cmd_mask_i;
                        cnt_d   = CntW'(SETTLE_CYC - 1);
                        state_d = StStallWait;
                     end
                     default: ;
                  endcase
               end
            end
         end
         StStallWait: begin
            if (cnt_q == '0) begin
               state_d = StRstAssert;
               cnt_d   = CntW'(RST_LEN - 1);
               crst_d  = mask_q;
            end
         end
         StRstAssert: begin
            crst_d = mask_q;
            if (cnt_q == '0) begin
               state_d = StRstRelease;
               cnt_d   = CntW'(SETTLE_CYC - 1);
               crst_d  = '0;
            end
         end
         StRstRelease: begin
            if (cnt_q == '0) begin
               state_d = StDone;
               cnt_d   = '0;
               hit_d   = hit_q & ~mask_q;
            end
         end
         StDone: begin
            state_d = StIdle;
            cnt_d   = '0;
         end
         default: begin
            state_d = StIdle;
            cnt_d   = '0;
         end
      endcase

      // Breakpoints are applied last so they override any command clear.
      hit_d = hit_d | bp_i;
      if (BP_STALL_ALL) begin
         if (|bp_i) stall_d = '1;
      end else begin
         stall_d = stall_d | bp_i;
      end
   end

   assign stall_o     = stall_q | bp_i;
   assign cpu_rst_o   = crst_q;
   assign bp_hit_o    = hit_q;
   assign cmd_ready_o = (state_q == StIdle);
   assign busy_o      = (state_q != StIdle);
   assign cmd_done_o  = (state_q == StDone);

endmodule

// File: tb/tb_adbg_or1k_stall_sequencer.sv
// Bench for adbg_or1k_stall_sequencer: per-cycle vector table through a scoreboard queue,
// plus a hand sequence for a command held valid across a RESET sequence.
module tb_adbg_or1k_stall_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       valid;
   logic [1:0] op;
   logic [3:0] mask;
   logic [3:0] bp;

   logic       ready, busy, done;
   logic [3:0] stall, crst, hit;
   logic       ready0, busy0, done0;
   logic [3:0] stall0, crst0, hit0;

   always #5 clk = ~clk;

   adbg_or1k_stall_sequencer #(
      .NB_CORES(4), .SETTLE_CYC(2), .RST_LEN(3), .BP_STALL_ALL(1'b1)
   ) dut (
      .tck_i(clk), .rst_i(rst), .cmd_valid_i(valid), .cmd_ready_o(ready),
      .cmd_op_i(op), .cmd_mask_i(mask), .bp_i(bp), .stall_o(stall),
      .cpu_rst_o(crst), .bp_hit_o(hit), .busy_o(busy), .cmd_done_o(done)
   );

   adbg_or1k_stall_sequencer #(
      .NB_CORES(4), .SETTLE_CYC(2), .RST_LEN(3), .BP_STALL_ALL(1'b0)
   ) dut0 (
      .tck_i(clk), .rst_i(rst), .cmd_valid_i(valid), .cmd_ready_o(ready0),
      .cmd_op_i(op), .cmd_mask_i(mask), .bp_i(bp), .stall_o(stall0),
      .cpu_rst_o(crst0), .bp_hit_o(hit0), .busy_o(busy0), .cmd_done_o(done0)
   );

   typedef struct {
      logic       rst;
      logic       valid;
      logic [1:0] op;
      logic [3:0] mask;
      logic [3:0] bp;
      logic [3:0] stall;
      logic [3:0] stall0;
      logic [3:0] crst;
      logic [3:0] hit;
      logic       busy;
      logic       done;
      logic       ready;
   } vec_t;

   vec_t vecs[$];
   vec_t sb[$];
   int   total = 0;
   int   bad = 0;

   function automatic vec_t mk(logic r, logic v, logic [1:0] o, logic [3:0] m, logic [3:0] b,
                               logic [3:0] s, logic [3:0] s0, logic [3:0] cr, logic [3:0] h,
                               logic bs, logic dn, logic rd);
      vec_t x;
      x.rst = r; x.valid = v; x.op = o; x.mask = m; x.bp = b;
      x.stall = s; x.stall0 = s0; x.crst = cr; x.hit = h;
      x.busy = bs; x.done = dn; x.ready = rd;
      return x;
   endfunction

   task automatic chk(input string name, input int row, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s row %0d: got %0h want %0h", name, row, act, exp);
      end
   endtask

   task automatic apply(input int row, input vec_t v);
      vec_t e;
      @(posedge clk);
      #1;
      rst = v.rst; valid = v.valid; op = v.op; mask = v.mask; bp = v.bp;
      sb.push_back(v);
      @(negedge clk);
      e = sb.pop_front();
      chk("stall", row, 32'(stall), 32'(e.stall));
      chk("stall_nobcast", row, 32'(stall0), 32'(e.stall0));
      chk("cpu_rst", row, 32'(crst), 32'(e.crst));
      chk("bp_hit", row, 32'(hit), 32'(e.hit));
      chk("busy", row, 32'(busy), 32'(e.busy));
      chk("done", row, 32'(done), 32'(e.done));
      chk("ready", row, 32'(ready), 32'(e.ready));
   endtask

   initial begin
      int accepts, dones, acc_k;

      rst = 1'b1; valid = 1'b0; op = 2'b00; mask = 4'h0; bp = 4'h0;

      // rst v op mask bp | stall stall0 crst hit busy done ready
      vecs.push_back(mk(0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 1));
      vecs.push_back(mk(0, 1, 1, 4'h5, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 1));
      vecs.push_back(mk(0, 0, 0, 4'h0, 4'h0, 4'h5, 4'h5, 4'h0, 4'h0, 1, 1, 0));
      vecs.push_back(mk(0, 0, 0, 4'h0, 4'h0, 4'h5, 4'h5, 4'h0, 4'h0, 0, 0, 1));
      vecs.push_back(mk(0, 1, 1, 4'hF, 4'h0, 4'h5, 4'h5, 4'h0, 4'h0, 0, 0, 1));
      vecs.push_back(mk(0, 0, 0, 4'h0, 4'h0, 4'hF, 4'hF, 4'h0, 4'h0, 1, 1, 0));
      vecs.push_back(mk(0, 0, 0, 4'h0, 4'h0, 4'hF, 4'hF, 4'h0, 4'h0, 0, 0, 1));
      // UNSTALL 0011 racing a breakpoint on core 0
      vecs.push_back(mk(0, 1, 2, 4'h3, 4'h1, 4'hF, 4'hF, 4'h0, 4'h0, 0, 0, 1));
      vecs.push_back(mk(0, 0, 0, 4'h0, 4'h0, 4'hF, 4'hD, 4'h0, 4'h1, 1, 1, 0));
      vecs.push_back(mk(0, 0, 0, 4'h0, 4'h0, 4'hF, 4'hD, 4'h0, 4'h1, 0, 0, 1));
      vecs.push_back(mk(0, 1, 2, 4'hF, 4'h0, 4'hF, 4'hD, 4'h0, 4'h1, 0, 0, 1));
      vecs.push_back(mk(0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1, 1, 0));
      vecs.push_back(mk(0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 1));
      // RESET core 1: settle 2, pulse 3, settle 2, done at T+8
      vecs.push_back(mk(0, 1, 3, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 1));
      vecs.push_back(mk(0, 0, 0, 4'h0, 4'h0, 4'h2, 4'h2, 4'h0, 4'h0, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 4'h0, 4'h0, 4'h2, 4'h2, 4'h0, 4'h0, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 4'h0, 4'h0, 4'h2, 4'h2, 4'h2, 4'h0, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 4'h0, 4'h0, 4'h2, 4'h2, 4'h2, 4'h0, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 4'h0, 4'h0, 4'h2, 4'h2, 4'h2, 4'h0, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 4'h0, 4'h0, 4'h2, 4'h2, 4'h0, 4'h0, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 4'h0, 4'h0, 4'h2, 4'h2, 4'h0, 4'h0, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 4'h0, 4'h0, 4'h2, 4'h2, 4'h0, 4'h0, 1, 1, 0));
      vecs.push_back(mk(0, 1, 2, 4'h2, 4'h0, 4'h2, 4'h2, 4'h0, 4'h0, 0, 0, 1));
      vecs.push_back(mk(0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1, 1, 0));
      vecs.push_back(mk(0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 1));
      // Idle breakpoint on core 2: broadcast vs. local stall
      vecs.push_back(mk(0, 0, 0, 4'h0, 4'h4, 4'h4, 4'h4, 4'h0, 4'h0, 0, 0, 1));
      vecs.push_back(mk(0, 0, 0, 4'h0, 4'h0, 4'hF, 4'h4, 4'h0, 4'h4, 0, 0, 1));
      vecs.push_back(mk(0, 1, 2, 4'hF, 4'h0, 4'hF, 4'h4, 4'h0, 4'h4, 0, 0, 1));
      vecs.push_back(mk(0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1, 1, 0));
      // NOP, then STALL with empty mask
      vecs.push_back(mk(0, 1, 0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 1));
      vecs.push_back(mk(0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1, 1, 0));
      vecs.push_back(mk(0, 1, 1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 1));
      vecs.push_back(mk(0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1, 1, 0));
      vecs.push_back(mk(0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 1));
      // RESET core 0 aborted by rst at T+4
      vecs.push_back(mk(0, 1, 3, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 1));
      vecs.push_back(mk(0, 0, 0, 4'h0, 4'h0, 4'h1, 4'h1, 4'h0, 4'h0, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 4'h0, 4'h0, 4'h1, 4'h1, 4'h0, 4'h0, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 4'h0, 4'h0, 4'h1, 4'h1, 4'h1, 4'h0, 1, 0, 0));
      vecs.push_back(mk(1, 0, 0, 4'h0, 4'h0, 4'h1, 4'h1, 4'h1, 4'h0, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 4'h0, 4'h8, 4'h8, 4'h8, 4'h0, 4'h0, 0, 0, 1));
      vecs.push_back(mk(0, 0, 0, 4'h0, 4'h0, 4'hF, 4'h8, 4'h0, 4'h8, 0, 0, 1));
      vecs.push_back(mk(0, 1, 2, 4'hF, 4'h0, 4'hF, 4'h8, 4'h0, 4'h8, 0, 0, 1));
      vecs.push_back(mk(0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1, 1, 0));
      vecs.push_back(mk(0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 1));

      repeat (2) @(posedge clk);
      for (int i = 0; i < vecs.size(); i++) apply(i, vecs[i]);

      // RESET core 0, then hold a STALL of core 3 valid while busy.
      @(posedge clk);
      #1;
      rst = 1'b0; valid = 1'b1; op = 2'b11; mask = 4'h1; bp = 4'h0;
      @(negedge clk);
      chk("hold_first_accept", 0, 32'(ready), 32'd1);
      @(posedge clk);
      #1;
      op = 2'b01; mask = 4'h8;
      accepts = 0; dones = 0; acc_k = 0;
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         if (done) dones++;
         if (valid && ready) begin
            accepts++;
            acc_k = k;
         end
         @(posedge clk);
         #1;
         if (acc_k != 0) valid = 1'b0;
      end
      chk("hold_accepts", 0, 32'(accepts), 32'd1);
      chk("hold_accept_cycle", 0, 32'(acc_k), 32'd9);
      chk("hold_dones", 0, 32'(dones), 32'd2);
      chk("hold_stall", 0, 32'(stall), 32'h9);
      chk("hold_stall_nobcast", 0, 32'(stall0), 32'h9);
      chk("hold_cpu_rst", 0, 32'(crst), 32'h0);
      chk("hold_idle", 0, 32'(busy), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
